arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width of each channel and of the output.
REQ-002 Parameter N, default 4: number of input channels; legal range 2..16; N need not be a power of two.
REQ-003 Parameter MODE, default 1: arbitration mode, 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 Localparam SW = clog2(N): selector/index width.
REQ-005 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1: one clock; reset is synchronous and active-high.
REQ-007 Port in_data  input  N*WIDTH: packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port in_valid  input  N: channel i offers a word.
REQ-009 Port in_ready  output  N: channel i's word is accepted this cycle.
REQ-010 Port force_en  input  1: restrict eligibility to channel force_sel only.
REQ-011 Port force_sel  input  SW: channel index used while force_en = 1.
REQ-012 Port out_data  output  WIDTH: registered selected word.
REQ-013 Port out_sel  output  SW: index of the channel that supplied out_data.
REQ-014 Port out_valid  output  1: out_data/out_sel hold an undelivered word.
REQ-015 Port out_ready  input  1: consumer accepts the output word this cycle.

Function
REQ-016 Output stage: one-entry register; load_en = ~out_valid | out_ready.
REQ-017 Eligible set: in_valid masked to bit force_sel when force_en = 1; otherwise all in_valid bits.
REQ-018 force_sel >= N with force_en = 1: eligible set empty, no grant, in_ready all 0.
REQ-019 MODE 0: grant = lowest-index eligible channel.
REQ-020 MODE 1: grant = first eligible channel searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-021 Grant is combinational from the current inputs and ptr; at most one in_ready bit is high, and only when load_en = 1.
REQ-022 in_ready[g] = 1 for granted channel g when load_en = 1; the handshake completes when in_valid[g] & in_ready[g].
REQ-023 On handshake: next cycle out_data = word of channel g, out_sel = g, out_valid = 1 (latency 1 cycle, input to output).
REQ-024 out_ready = 1 with no handshake: out_valid clears next cycle; out_data and out_sel hold their values.
REQ-025 out_valid = 1 & out_ready = 0: out_data, out_sel, out_valid held stable; in_ready all 0 (backpressure).
REQ-026 out_valid = 1 & out_ready = 1 with a grant: the old word drains and the new word loads in the same cycle, giving full throughput of one word per cycle.
REQ-027 ptr (SW bits, MODE 1 only) updates on handshake only: ptr = g+1, wrapping to 0 when g = N-1; ptr never holds a value >= N.
REQ-028 In MODE 0, ptr is unused and remains 0.
REQ-029 Changes of force_en/force_sel take effect in the same cycle; they do not disturb the word held in the output register or ptr.
REQ-030 No eligible channel and load_en = 1: no load; out_valid follows REQ-024.

Reset
REQ-031 While rst = 1 at a clk edge: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
REQ-032 While rst = 1, in_ready is forced to all 0; no handshake occurs.
REQ-033 Reset asserted mid-operation: a held, undelivered output word is discarded, without error indication.
REQ-034 First cycle after rst deasserts: arbitration starts from ptr = 0.

Verification
REQ-035 MODE 1, N=4, all in_valid = 1 continuously, out_ready = 1 -> out_sel sequence is 0,1,2,3,0,1, with one word per cycle and out_valid constantly 1.
REQ-036 MODE 0, N=4, in_valid = 4'b1010, out_ready = 1 -> out_sel = 1 on every word; channel 3 is never granted while channel 1 stays valid.
REQ-037 Channel 2 delivers 0xDEADBEEF, then out_ready = 0 for 3 cycles -> out_data = 0xDEADBEEF, out_sel = 2, out_valid = 1 held, in_ready = 0 throughout; the word is released on the first out_ready = 1 cycle.
REQ-038 force_en = 1, force_sel = 3, in_valid = 4'b1111 -> only channel 3 is granted; force_sel = 5 with N = 8 and in_valid[5] = 0 -> no grant and out_valid drops after draining.
REQ-039 N=3, MODE 1, grant to channel 2 -> ptr wraps to 0, and the next grant with all channels valid goes to channel 0.
REQ-040 rst pulsed for 1 cycle while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, out_data = 0, out_sel = 0, and arbitration restarts at channel 0.

Source files
------------

// File: rtl/arb_mux.sv
// arb_mux: N-channel fixed-priority/round-robin arbiter into a one-entry registered output (in_*: channel handshake, force_*: eligibility override, out_*: registered word)
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  parameter int MODE = 1,
  localparam int SW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             force_en,
  input  logic [SW-1:0]    force_sel,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_sel,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] ch [N];
  logic [N-1:0] elig;
  logic [SW:0] sum;
  logic [SW-1:0] idx, gnt, ptr_q, ptr_d, out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic gnt_v, load_en, hs, out_valid_q, out_valid_d;
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch[i] = in_data[i*WIDTH +: WIDTH];
    assign elig[i] = in_valid[i] & (~force_en | (force_sel == SW'(i)));
  end
  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    sum = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = (MODE == 0 ? '0 : {1'b0, ptr_q}) + (SW+1)'(k);
      idx = SW'(sum >= (SW+1)'(N) ? sum - (SW+1)'(N) : sum);
      if (elig[idx]) begin
        gnt_v = 1'b1;
        gnt = idx;
      end
    end
  end
  assign load_en = ~out_valid_q | out_ready;
  assign hs = gnt_v & load_en & ~rst;
  assign in_ready = hs ? N'(1) << gnt : '0;
  always_comb begin
    out_valid_d = hs | (out_valid_q & ~out_ready);
    out_data_d = hs ? ch[gnt] : out_data_q;
    out_sel_d = hs ? gnt : out_sel_q;
    ptr_d = (MODE == 0) ? '0 : hs ? (gnt == SW'(N - 1) ? '0 : gnt + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed bench for arb_mux in round-robin, fixed-priority, N=8 and N=3 configurations
module tb_arb_mux;
  logic clk = 0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;

  logic a_rst, a_fe, a_ov, a_or;
  logic [127:0] a_id;
  logic [3:0] a_iv, a_ir;
  logic [1:0] a_fs, a_os;
  logic [31:0] a_od;
  arb_mux #(.WIDTH(32), .N(4), .MODE(1)) u_a (
    .clk(clk), .rst(a_rst), .in_data(a_id), .in_valid(a_iv), .in_ready(a_ir),
    .force_en(a_fe), .force_sel(a_fs), .out_data(a_od), .out_sel(a_os),
    .out_valid(a_ov), .out_ready(a_or));

  logic b_rst, b_fe, b_ov, b_or;
  logic [127:0] b_id;
  logic [3:0] b_iv, b_ir;
  logic [1:0] b_fs, b_os;
  logic [31:0] b_od;
  arb_mux #(.WIDTH(32), .N(4), .MODE(0)) u_b (
    .clk(clk), .rst(b_rst), .in_data(b_id), .in_valid(b_iv), .in_ready(b_ir),
    .force_en(b_fe), .force_sel(b_fs), .out_data(b_od), .out_sel(b_os),
    .out_valid(b_ov), .out_ready(b_or));

  logic c_rst, c_fe, c_ov, c_or;
  logic [255:0] c_id;
  logic [7:0] c_iv, c_ir;
  logic [2:0] c_fs, c_os;
  logic [31:0] c_od;
  arb_mux #(.WIDTH(32), .N(8), .MODE(1)) u_c (
    .clk(clk), .rst(c_rst), .in_data(c_id), .in_valid(c_iv), .in_ready(c_ir),
    .force_en(c_fe), .force_sel(c_fs), .out_data(c_od), .out_sel(c_os),
    .out_valid(c_ov), .out_ready(c_or));

  logic d_rst, d_fe, d_ov, d_or;
  logic [95:0] d_id;
  logic [2:0] d_iv, d_ir;
  logic [1:0] d_fs, d_os;
  logic [31:0] d_od;
  arb_mux #(.WIDTH(32), .N(3), .MODE(1)) u_d (
    .clk(clk), .rst(d_rst), .in_data(d_id), .in_valid(d_iv), .in_ready(d_ir),
    .force_en(d_fe), .force_sel(d_fs), .out_data(d_od), .out_sel(d_os),
    .out_valid(d_ov), .out_ready(d_or));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1; b_rst = 1; c_rst = 1; d_rst = 1;
    a_fe = 0; b_fe = 0; c_fe = 0; d_fe = 0;
    a_fs = 0; b_fs = 0; c_fs = 0; d_fs = 0;
    a_or = 0; b_or = 0; c_or = 0; d_or = 0;
    a_iv = 4'b1111; b_iv = 0; c_iv = 0; d_iv = 0;
    for (int i = 0; i < 4; i++) a_id[i*32 +: 32] = 32'h100 + i;
    for (int i = 0; i < 4; i++) b_id[i*32 +: 32] = 32'h200 + i;
    for (int i = 0; i < 8; i++) c_id[i*32 +: 32] = 32'h300 + i;
    for (int i = 0; i < 3; i++) d_id[i*32 +: 32] = 32'h400 + i;
    step();
    step();
    chk("rst_valid", a_ov, 0);
    chk("rst_data", a_od, 0);
    chk("rst_sel", a_os, 0);
    chk("rst_ready", a_ir, 0);
    a_rst = 0; b_rst = 0; c_rst = 0; d_rst = 0;
    a_or = 1;
    #1;
    chk("rr_first_ready", a_ir, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_sel", a_os, k % 4);
      chk("rr_valid", a_ov, 1);
      chk("rr_data", a_od, 32'h100 + (k % 4));
    end
    a_iv = 4'b0100;
    a_id[64 +: 32] = 32'hDEADBEEF;
    #1;
    chk("bp_grant", a_ir, 4'b0100);
    step();
    a_or = 0;
    a_iv = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", a_ir, 0);
      chk("bp_data", a_od, 32'hDEADBEEF);
      chk("bp_sel", a_os, 2);
      chk("bp_valid", a_ov, 1);
      step();
    end
    chk("bp_hold_data", a_od, 32'hDEADBEEF);
    a_or = 1;
    a_iv = 0;
    step();
    chk("drain_valid", a_ov, 0);
    chk("drain_data", a_od, 32'hDEADBEEF);
    chk("drain_sel", a_os, 2);
    a_fe = 1; a_fs = 3; a_iv = 4'b1111;
    #1;
    chk("force_ready", a_ir, 4'b1000);
    step();
    chk("force_sel1", a_os, 3);
    chk("force_ready2", a_ir, 4'b1000);
    step();
    chk("force_sel2", a_os, 3);
    a_fe = 0;
    a_iv = 4'b0010;
    step();
    chk("pre_rst_sel", a_os, 1);
    a_or = 0;
    a_iv = 0;
    step();
    chk("pre_rst_valid", a_ov, 1);
    a_rst = 1;
    step();
    a_rst = 0;
    chk("midrst_valid", a_ov, 0);
    chk("midrst_data", a_od, 0);
    chk("midrst_sel", a_os, 0);
    a_iv = 4'b1111; a_or = 1;
    #1;
    chk("midrst_restart", a_ir, 4'b0001);
    step();
    chk("midrst_sel0", a_os, 0);

    b_iv = 4'b1010; b_or = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fp_ready", b_ir, 4'b0010);
      step();
      chk("fp_sel", b_os, 1);
      chk("fp_data", b_od, 32'h201);
    end
    b_iv = 4'b1100;
    step();
    chk("fp_sel2", b_os, 2);

    c_iv = 8'hFF; c_or = 1;
    step();
    chk("n8_sel", c_os, 0);
    chk("n8_valid", c_ov, 1);
    c_fe = 1; c_fs = 5; c_iv = 8'b1101_1111;
    #1;
    chk("n8_force_none", c_ir, 0);
    step();
    chk("n8_drain_valid", c_ov, 0);
    chk("n8_drain_sel", c_os, 0);

    d_iv = 3'b100; d_or = 1;
    #1;
    chk("n3_ready2", d_ir, 3'b100);
    step();
    chk("n3_sel2", d_os, 2);
    d_iv = 3'b111;
    #1;
    chk("n3_wrap_ready", d_ir, 3'b001);
    step();
    chk("n3_wrap_sel", d_os, 0);
    chk("n3_wrap_data", d_od, 32'h400);
    d_fe = 1; d_fs = 3;
    #1;
    chk("n3_force_oob", d_ir, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
